// File: rtl/sram_burst_master_if.sv
// Command, write/read data streams and SRAM pins of the burst master.
// master = the burst master's view, slave = the command issuer / SRAM side.
interface sram_burst_master_if #(
   parameter int DATA_WIDTH     = 128,
   parameter int MAX_ADDR       = 128,
   parameter int ADDR_BIT_WIDTH = $clog2(MAX_ADDR),
   parameter int LEN_WIDTH      = 8
);
   logic                      i_cmd_valid;
   logic                      o_cmd_ready;
   logic                      i_cmd_wr;
   logic [ADDR_BIT_WIDTH-1:0] i_cmd_addr;
   logic [LEN_WIDTH-1:0]      i_cmd_len;

   logic                      i_wvalid;
   logic                      o_wready;
   logic [DATA_WIDTH-1:0]     i_wdata;

   logic                      o_rvalid;
   logic                      i_rready;
   logic [DATA_WIDTH-1:0]     o_rdata;

   logic                      o_done;
   logic                      o_cs_n;
   logic                      o_we_n;
   logic [ADDR_BIT_WIDTH-1:0] o_addr;
   logic [DATA_WIDTH-1:0]     o_wdata;
   logic [DATA_WIDTH-1:0]     i_rdata;

   modport master (
      input  i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_len,
      input  i_wvalid, i_wdata, i_rready, i_rdata,
      output o_cmd_ready, o_wready, o_rvalid, o_rdata,
      output o_done, o_cs_n, o_we_n, o_addr, o_wdata
   );

   modport slave (
      output i_cmd_valid, i_cmd_wr, i_cmd_addr, i_cmd_len,
      output i_wvalid, i_wdata, i_rready, i_rdata,
      input  o_cmd_ready, o_wready, o_rvalid, o_rdata,
      input  o_done, o_cs_n, o_we_n, o_addr, o_wdata
   );
endinterface

// File: rtl/sram_burst_master.sv
// Burst master for a single-port synchronous SRAM: writes at one beat per cycle,
// reads at one beat per two cycles with a registered, back-pressured read stream.
//
// state   | meaning
// IDLE    | waiting for a command, o_cmd_ready high
// WR      | accepting write beats, each accepted beat becomes an SRAM write next cycle
// RD_ADDR | SRAM read strobe active for the current address
// RD_WAIT | read beat held on o_rdata until the consumer takes it
// DONE    | one-cycle o_done pulse, SRAM idle (last write lands here)
module sram_burst_master #(
   parameter int DATA_WIDTH     = 128,
   parameter int MAX_ADDR       = 128,
   parameter int ADDR_BIT_WIDTH = $clog2(MAX_ADDR),
   parameter int LEN_WIDTH      = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   sram_burst_master_if.master  bus
);

   localparam int AW1 = ADDR_BIT_WIDTH + 1;
   localparam logic [AW1-1:0]            LP_MAX  = AW1'(MAX_ADDR);
   localparam logic [ADDR_BIT_WIDTH-1:0] LP_LAST = ADDR_BIT_WIDTH'(MAX_ADDR - 1);

   typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, DONE} state_t;

   state_t                    r_state, w_state_nxt;
   logic [ADDR_BIT_WIDTH-1:0] r_addr, w_addr_nxt;
   logic [LEN_WIDTH-1:0]      r_cnt, w_cnt_nxt;
   logic                      r_cs_n, w_cs_n_nxt;
   logic                      r_we_n, w_we_n_nxt;
   logic [ADDR_BIT_WIDTH-1:0] r_sram_addr, w_sram_addr_nxt;
   logic [DATA_WIDTH-1:0]     r_sram_wdata, w_sram_wdata_nxt;
   logic [DATA_WIDTH-1:0]     r_rdata, w_rdata_nxt;
   logic                      r_rvalid, w_rvalid_nxt;

   logic                      w_cmd_ready, w_wready, w_done;
   logic [ADDR_BIT_WIDTH-1:0] w_start_addr, w_addr_inc;
   logic                      w_last;

   // Out-of-range start addresses restart the burst at word 0.
   assign w_start_addr = ({1'b0, bus.i_cmd_addr} >= LP_MAX) ? '0 : bus.i_cmd_addr;
   assign w_addr_inc   = (r_addr == LP_LAST) ? '0 : r_addr + ADDR_BIT_WIDTH'(1);
   assign w_last       = (r_cnt == '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_cnt        <= '0;
         r_cs_n       <= 1'b1;
         r_we_n       <= 1'b1;
         r_sram_addr  <= '0;
         r_sram_wdata <= '0;
         r_rdata      <= '0;
         r_rvalid     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_cnt        <= w_cnt_nxt;
         r_cs_n       <= w_cs_n_nxt;
         r_we_n       <= w_we_n_nxt;
         r_sram_addr  <= w_sram_addr_nxt;
         r_sram_wdata <= w_sram_wdata_nxt;
         r_rdata      <= w_rdata_nxt;
         r_rvalid     <= w_rvalid_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.i_cmd_valid) w_state_nxt = bus.i_cmd_wr ? WR : RD_ADDR;
         WR:      if (bus.i_wvalid && w_last) w_state_nxt = DONE;
         RD_ADDR: w_state_nxt = RD_WAIT;
         RD_WAIT: if (bus.i_rready) w_state_nxt = w_last ? DONE : RD_ADDR;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_addr_nxt       = r_addr;
      w_cnt_nxt        = r_cnt;
      w_cs_n_nxt       = 1'b1;
      w_we_n_nxt       = 1'b1;
      w_sram_addr_nxt  = r_sram_addr;
      w_sram_wdata_nxt = r_sram_wdata;
      w_rdata_nxt      = r_rdata;
      w_rvalid_nxt     = r_rvalid;
      w_cmd_ready      = i_rst_n && (r_state == IDLE);
      w_wready         = i_rst_n && (r_state == WR);
      w_done           = (r_state == DONE);
      case (r_state)
         IDLE: begin
            if (bus.i_cmd_valid) begin
               w_addr_nxt = w_start_addr;
               w_cnt_nxt  = bus.i_cmd_len;
               if (!bus.i_cmd_wr) begin
                  w_cs_n_nxt      = 1'b0;
                  w_sram_addr_nxt = w_start_addr;
               end
            end
         end
         WR: begin
            if (bus.i_wvalid) begin
               w_cs_n_nxt       = 1'b0;
               w_we_n_nxt       = 1'b0;
               w_sram_addr_nxt  = r_addr;
               w_sram_wdata_nxt = bus.i_wdata;
               w_addr_nxt       = w_addr_inc;
               if (!w_last) w_cnt_nxt = r_cnt - LEN_WIDTH'(1);
            end
         end
         RD_ADDR: begin
            w_rdata_nxt  = bus.i_rdata;
            w_rvalid_nxt = 1'b1;
         end
         RD_WAIT: begin
            if (bus.i_rready) begin
               w_rvalid_nxt = 1'b0;
               if (!w_last) begin
                  w_cnt_nxt       = r_cnt - LEN_WIDTH'(1);
                  w_addr_nxt      = w_addr_inc;
                  w_cs_n_nxt      = 1'b0;
                  w_sram_addr_nxt = w_addr_inc;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.o_cmd_ready = w_cmd_ready;
   assign bus.o_wready    = w_wready;
   assign bus.o_done      = w_done;
   assign bus.o_rvalid    = r_rvalid;
   assign bus.o_rdata     = r_rdata;
   assign bus.o_cs_n      = r_cs_n;
   assign bus.o_we_n      = r_we_n;
   assign bus.o_addr      = r_sram_addr;
   assign bus.o_wdata     = r_sram_wdata;

endmodule

// File: tb/tb_sram_burst_master.sv
// Bench for sram_burst_master: behavioural SRAM, a flat reference memory and
// expected write logs built from burst arithmetic ((start + i) mod 128).
module tb_sram_burst_master;

   localparam int DW = 128;
   localparam int MA = 128;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   typedef struct {int cyc; int a; logic [DW-1:0] d;} wr_t;
   wr_t  wr_log[$];
   wr_t  exp_wr[$];
   int   done_log[$];

   logic [DW-1:0] sram    [MA];
   logic [DW-1:0] ref_mem [MA];

   sram_burst_master_if #(.DATA_WIDTH(DW), .MAX_ADDR(MA)) bus ();

   sram_burst_master #(.DATA_WIDTH(DW), .MAX_ADDR(MA)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.i_rdata = (!bus.o_cs_n && bus.o_we_n) ? sram[bus.o_addr] : '0;

   always @(negedge clk) begin
      if (!bus.o_cs_n && !bus.o_we_n) begin
         sram[bus.o_addr] = bus.o_wdata;
         wr_log.push_back('{cyc, int'(bus.o_addr), bus.o_wdata});
      end
      if (bus.o_done) done_log.push_back(cyc);
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // pat bit k = i_wvalid in the k-th WR cycle (all ones after 32 cycles)
   task automatic wr_burst(input int a, input int len, input logic [31:0] pat, input logic [DW-1:0] dbase);
      int beat = 0;
      int k = 0;
      int cur;
      logic [DW-1:0] d;
      logic v;
      wr_log.delete();
      exp_wr.delete();
      cur = (a >= MA) ? 0 : a;
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_wr    = 1'b1;
      bus.i_cmd_addr  = 7'(a);
      bus.i_cmd_len   = 8'(len);
      chk("wr_cmd_ready", bus.o_cmd_ready, 1'b1);
      step();
      bus.i_cmd_valid = 1'b0;
      while (beat <= len && k < 100) begin
         chk("wr_wready", bus.o_wready, 1'b1);
         v = (k < 32) ? pat[k] : 1'b1;
         d = (dbase != '0) ? dbase + DW'(beat) : rnd_word();
         bus.i_wvalid = v;
         bus.i_wdata  = d;
         if (v) begin
            exp_wr.push_back('{cyc + 1, cur, d});
            ref_mem[cur] = d;
            cur = (cur + 1) % MA;
            beat++;
         end
         step();
         k++;
      end
      bus.i_wvalid = 1'b0;
      chk("wr_timeout", k < 100, 1'b1);
      chk("wr_done_pulse", bus.o_done, 1'b1);
      chk("wr_wready_done", bus.o_wready, 1'b0);
      chk("wr_cmd_ready_done", bus.o_cmd_ready, 1'b0);
      step();
      chk("wr_done_clear", bus.o_done, 1'b0);
      chk("wr_back_idle", bus.o_cmd_ready, 1'b1);
      chk("wr_count", wr_log.size(), exp_wr.size());
      for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
         chk("wr_addr", wr_log[i].a, exp_wr[i].a);
         chk("wr_data", wr_log[i].d, exp_wr[i].d);
         chk("wr_cycle", wr_log[i].cyc, exp_wr[i].cyc);
      end
   endtask

   task automatic rd_burst(input int a, input int len, input int stall_beat, input int stall_cycles, input bit rnd_stall);
      int cur;
      int stall;
      cur = (a >= MA) ? 0 : a;
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_wr    = 1'b0;
      bus.i_cmd_addr  = 7'(a);
      bus.i_cmd_len   = 8'(len);
      chk("rd_cmd_ready", bus.o_cmd_ready, 1'b1);
      step();
      bus.i_cmd_valid = 1'b0;
      for (int beat = 0; beat <= len; beat++) begin
         chk("rd_strobe_cs", bus.o_cs_n, 1'b0);
         chk("rd_strobe_we", bus.o_we_n, 1'b1);
         chk("rd_strobe_addr", bus.o_addr, cur);
         chk("rd_strobe_rvalid", bus.o_rvalid, 1'b0);
         step();
         stall = (beat == stall_beat) ? stall_cycles : (rnd_stall ? int'($urandom_range(0, 2)) : 0);
         bus.i_rready = 1'b0;
         for (int s = 0; s < stall; s++) begin
            chk("rd_stall_rvalid", bus.o_rvalid, 1'b1);
            chk("rd_stall_rdata", bus.o_rdata, ref_mem[cur]);
            chk("rd_stall_cs", bus.o_cs_n, 1'b1);
            step();
         end
         chk("rd_rvalid", bus.o_rvalid, 1'b1);
         chk("rd_rdata", bus.o_rdata, ref_mem[cur]);
         chk("rd_cs_idle", bus.o_cs_n, 1'b1);
         bus.i_rready = 1'b1;
         step();
         bus.i_rready = 1'b0;
         cur = (cur + 1) % MA;
      end
      chk("rd_done_pulse", bus.o_done, 1'b1);
      chk("rd_done_rvalid", bus.o_rvalid, 1'b0);
      chk("rd_done_cs", bus.o_cs_n, 1'b1);
      step();
      chk("rd_done_clear", bus.o_done, 1'b0);
      chk("rd_back_idle", bus.o_cmd_ready, 1'b1);
   endtask

   initial begin
      int a;
      int len;
      for (int i = 0; i < MA; i++) begin
         sram[i]    = '0;
         ref_mem[i] = '0;
      end
      bus.i_cmd_valid = 1'b0;
      bus.i_cmd_wr    = 1'b0;
      bus.i_cmd_addr  = '0;
      bus.i_cmd_len   = '0;
      bus.i_wvalid    = 1'b0;
      bus.i_wdata     = '0;
      bus.i_rready    = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", bus.o_cmd_ready, 1'b0);
      chk("rst_wready", bus.o_wready, 1'b0);
      chk("rst_cs_n", bus.o_cs_n, 1'b1);
      chk("rst_we_n", bus.o_we_n, 1'b1);
      chk("rst_addr", bus.o_addr, 0);
      chk("rst_wdata", bus.o_wdata, 0);
      chk("rst_rdata", bus.o_rdata, 0);
      chk("rst_rvalid", bus.o_rvalid, 1'b0);
      chk("rst_done", bus.o_done, 1'b0);
      rst_n = 1'b1;
      step();
      chk("rel_cmd_ready", bus.o_cmd_ready, 1'b1);
      repeat (2) step();
      chk("idle_cs_n", bus.o_cs_n, 1'b1);
      chk("idle_cmd_ready", bus.o_cmd_ready, 1'b1);

      // directed bursts
      wr_burst(5, 3, 32'hFFFF_FFFF, 128'hA0);
      rd_burst(5, 3, -1, 0, 1'b0);
      wr_burst(126, 3, 32'hFFFF_FFFF, '0);
      rd_burst(126, 3, -1, 0, 1'b0);
      rd_burst(5, 3, 1, 5, 1'b0);
      wr_burst(20, 1, 32'hFFFF_FFF9, '0);
      chk("gap_writes", wr_log.size(), 2);
      rd_burst(20, 1, -1, 0, 1'b0);

      // randomized bursts
      for (int it = 0; it < 6; it++) begin
         a   = int'($urandom_range(0, MA - 1));
         len = int'($urandom_range(0, 7));
         wr_burst(a, len, $urandom() | $urandom(), '0);
         rd_burst(a, len, int'($urandom_range(0, len)), int'($urandom_range(0, 3)), 1'b1);
      end

      // reset during beat 2 of a 4-beat write
      wr_log.delete();
      done_log.delete();
      bus.i_cmd_valid = 1'b1;
      bus.i_cmd_wr    = 1'b1;
      bus.i_cmd_addr  = 7'd40;
      bus.i_cmd_len   = 8'd3;
      step();
      bus.i_cmd_valid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.i_wvalid = 1'b1;
         bus.i_wdata  = rnd_word();
         ref_mem[40 + b] = bus.i_wdata;
         step();
      end
      bus.i_wvalid = 1'b1;
      bus.i_wdata  = rnd_word();
      rst_n = 1'b0;
      #1;
      chk("abort_wready", bus.o_wready, 1'b0);
      chk("abort_cmd_ready", bus.o_cmd_ready, 1'b0);
      step();
      chk("abort_cs_n", bus.o_cs_n, 1'b1);
      chk("abort_we_n", bus.o_we_n, 1'b1);
      chk("abort_done", bus.o_done, 1'b0);
      chk("abort_addr", bus.o_addr, 0);
      chk("abort_wdata", bus.o_wdata, 0);
      rst_n = 1'b1;
      bus.i_wvalid = 1'b0;
      step();
      chk("abort_rel_ready", bus.o_cmd_ready, 1'b1);
      repeat (3) step();
      chk("abort_writes", wr_log.size(), 2);
      chk("abort_no_done", done_log.size(), 0);
      rd_burst(40, 1, -1, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_burst_master.md
SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 Parameter DATA_WIDTH, default 128, SRAM word width in bits.
REQ-002 Parameter MAX_ADDR, default 128, number of SRAM words.
REQ-003 Parameter ADDR_BIT_WIDTH, default $clog2(MAX_ADDR), SRAM address width.
REQ-004 Parameter LEN_WIDTH, default 8, burst length field width.
REQ-005 i_clk  input  1  clock; all state updates on rising edge.
REQ-006 i_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_cmd_valid  input  1  command offered.
REQ-008 o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-009 i_cmd_wr  input  1  1 = write burst, 0 = read burst.
REQ-010 i_cmd_addr  input  ADDR_BIT_WIDTH  burst start address.
REQ-011 i_cmd_len  input  LEN_WIDTH  beats minus one (0 = 1 beat).
REQ-012 i_wvalid / o_wready / i_wdata  in/out/in  1/1/DATA_WIDTH  write-data stream.
REQ-013 o_rvalid / i_rready / o_rdata  out/in/out  1/1/DATA_WIDTH  read-data stream.
REQ-014 o_done  output  1  one-cycle pulse at burst completion.
REQ-015 o_cs_n, o_we_n  output  1 each  SRAM chip select / write enable, active-low, registered.
REQ-016 o_addr / o_wdata  output  ADDR_BIT_WIDTH / DATA_WIDTH  SRAM address / write data, registered.
REQ-017 i_rdata  input  DATA_WIDTH  SRAM read data, valid combinationally while o_cs_n=0, o_we_n=1.

Function
REQ-018 FSM states SHALL be IDLE, WR, RD_ADDR, RD_WAIT, DONE.
REQ-019 IDLE: o_cmd_ready=1; on i_cmd_valid capture op, addr, len; go WR (write) or RD_ADDR (read); unaccepted cycles change nothing.
REQ-020 Start address >= MAX_ADDR SHALL be replaced by 0.
REQ-021 WR: o_wready=1; each i_wvalid&o_wready edge registers o_cs_n=0, o_we_n=0, o_addr=current addr, o_wdata=i_wdata for exactly the next cycle; throughput 1 beat/cycle.
REQ-022 WR cycle with i_wvalid=0 SHALL register o_cs_n=1, o_we_n=1 (no SRAM access); burst stalls.
REQ-023 Acceptance of last write beat SHALL move to DONE; the last SRAM write occurs during the DONE cycle.
REQ-024 RD_ADDR: o_cs_n=0, o_we_n=1, o_addr=current addr driven this cycle; at its closing edge o_rdata<=i_rdata, o_rvalid<=1, o_cs_n<=1; go RD_WAIT.
REQ-025 RD_WAIT: o_rvalid and o_rdata held stable until i_rready; on handshake o_rvalid<=0, next RD_ADDR if beats remain else DONE; minimum 2 cycles/beat.
REQ-026 Current address SHALL increment by 1 per beat, wrapping MAX_ADDR-1 -> 0.
REQ-027 Beat counter SHALL load i_cmd_len and decrement per beat; last beat when count==0.
REQ-028 DONE: o_done=1 for exactly one cycle, registers o_cs_n=1, o_we_n=1; next IDLE; o_cmd_ready=0 in DONE.
REQ-029 o_wready=0 outside WR; o_rvalid=0 outside RD_WAIT; o_cs_n, o_we_n never 0 together with a read pending.

Reset
REQ-030 While i_rst_n=0 at a rising edge: state=IDLE, o_cs_n=1, o_we_n=1, o_addr=0, o_wdata=0, o_rdata=0, o_rvalid=0, o_done=0, counters 0.
REQ-031 o_cmd_ready and o_wready SHALL be 0 while i_rst_n=0; o_cmd_ready=1 the first cycle after release.
REQ-032 Reset mid-burst SHALL abort the burst with no o_done pulse and no further SRAM access.

Verification
REQ-033 Write addr=5 len=3, data A0..A3 back-to-back -> SRAM writes at 5,6,7,8 on 4 consecutive cycles, o_done 1 cycle after last accept.
REQ-034 Read addr=5 len=3, i_rready=1 -> o_rdata A0..A3, one beat per 2 cycles, o_done after 4th handshake.
REQ-035 Write addr=126 len=3 (MAX_ADDR=128) -> addresses 126,127,0,1; read back matches.
REQ-036 Read with i_rready held low 5 cycles on beat 1 -> o_rvalid and o_rdata stable, o_cs_n=1 throughout stall.
REQ-037 Write with i_wvalid gaps (1,0,0,1) -> exactly 2 SRAM writes, no cs_n=0 in gap cycles.
REQ-038 Assert i_rst_n=0 during beat 2 of 4-beat write -> next cycle o_cs_n=1, no o_done, o_cmd_ready=1 after release.
